alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Hardwired control sequencer for the CPU datapath. It runs the fetch cycle (T0–T2), decodes the instruction register, and drives the one-hot register, bus and ALU controls for register-register ALU instructions and for the multiply/divide instructions that write HI/LO. It sits beside CPU_Datapath and replaces hand-sequenced control with a Moore state machine.

## Interface
Parameters:
- CNT_W, 16, width of the retired-instruction counter

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- clr  in  1  reset, asynchronous and active-high
- run  in  1  permits fetch of the next instruction
- mem_rdy  in  1  memory read data valid on Mdatain
- ir  in  32  datapath IR contents
- PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin  out  1 each  datapath strobes
- ZLOout, ZHIout, Loin, HIin  out  1 each  Z/HI/LO strobes
- Rout  out  16  one-hot register bus-drive enables (R0out..R15out)
- Rin  out  16  one-hot register load enables (R0in..R15in)
- ALUSelection  out  5  ALU operation code
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- illegal  out  1  one-cycle pulse on an undefined opcode
- retired  out  CNT_W  count of completed instructions, wraps to 0

## Operation
- Instruction fields: opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15].
- Opcode classes:
  - R3, opcodes 5'h03–5'h0B: Ra ← Rb op Rc. ALUSelection equals the opcode.
  - HL, 5'h0F (mul) and 5'h10 (div): {HI,LO} ← Ra op Rb. ALUSelection equals the opcode.
  - NOP, 5'h1A.
  - HALT, 5'h1B.
  - Every other opcode is illegal.
- States and the outputs asserted in each:
  - IDLE: no outputs.
  - F0: PCout, MARin, IncPC, Zin.
  - F1: ZLOout, PCin, Read, MDRin.
  - F2: MDRout, IRin.
  - DEC: no strobes; captures the opcode and the three register fields into internal registers.
  - E3: R3 asserts Rout[Rb], Yin. HL asserts Rout[Ra], Yin.
  - E4: R3 asserts Rout[Rc], Zin, ALUSelection. HL asserts Rout[Rb], Zin, ALUSelection.
  - E5: R3 asserts ZLOout, Rin[Ra]. HL asserts ZLOout, Loin.
  - E6 (HL only): ZHIout, HIin.
  - HALT: no strobes; halted=1.
- Transitions:
  - IDLE→F0 when run=1.
  - F0→F1.
  - F1 holds while mem_rdy=0. F1→F2 when mem_rdy=1.
  - F2→DEC.
  - DEC→E3 for R3 and HL.
  - DEC→HALT for the HALT opcode.
  - DEC→(F0 if run, else IDLE) for NOP and for illegal opcodes; illegal pulses in the cycle after DEC.
  - R3: E5 exits to F0 if run=1, else IDLE.
  - HL: E5→E6; E6 exits to F0 if run=1, else IDLE.
  - HALT is left only via clr.
- retired increments by 1 on the exit from the last execute state (E5 for R3, E6 for HL) and on the exit from DEC for NOP.
- Illegal and HALT instructions do not increment retired.
- Any strobe not listed for a state is 0. ALUSelection is 0 outside E4.

## Timing
- Moore outputs, decoded from the registered state only. Every strobe is high for exactly one full cycle per state visit; the datapath samples it on the next rising edge.
- Reset (clr=1): state=IDLE, all strobes 0, Rout=Rin=0, ALUSelection=0, busy=0, halted=0, illegal=0, retired=0, captured fields 0.
- clr asserted mid-instruction aborts immediately and asynchronously. There is no partial writeback after reset.
- Latency with mem_rdy held at 1, counted from the F0 entry edge:
  - R3: 7 cycles (F0–E5).
  - HL: 8 cycles.
  - NOP or illegal: 4 cycles.
- Each cycle with mem_rdy=0 in F1 adds one cycle. Read and MDRin stay high throughout the stall; PCin is high on every F1 cycle, which the datapath tolerates because Z is unchanged.
- run is sampled only in IDLE and at instruction exit. Deasserting run mid-instruction does not stop the current instruction.
- Ra=Rb=Rc, including R0, is legal. The one-hot encoding is unaffected.
- retired wraps from 2^CNT_W−1 to 0.

## Structure
- Package ctrl_pkg holds:
  - the state enum (IDLE, F0, F1, F2, DEC, E3, E4, E5, E6, HALT);
  - the opcode constants and class enum (R3, HL, NOP, HALT, ILL);
  - the field bit positions.
- Sub-module op_decoder is combinational: 5-bit opcode → class and ALU select. It is instantiated once in DEC.
- The top level contains the state register, the field registers, the retired counter, and the output decode using 4→16 one-hot decoders.

## Test plan
- clr pulse mid-E4 → next cycle: state IDLE, all outputs 0, retired=0.
- run=1, mem_rdy=1, ir=0x28918000 (opcode 5, Ra=1, Rb=2, Rc=3):
  - E3: Rout=16'h0004, Yin=1.
  - E4: Rout=16'h0008, ALUSelection=5, Zin=1.
  - E5: Rin=16'h0002, ZLOout=1.
  - retired=1 after 7 cycles.
- Opcode 5'h10, Ra=6, Rb=7:
  - E3: Rout[6]=1.
  - E4: Rout[7]=1, ALUSelection=5'h10.
  - E5: ZLOout=1, Loin=1.
  - E6: ZHIout=1, HIin=1.
  - 8 cycles total.
- mem_rdy held low for 3 cycles in F1 → F1 lasts 4 cycles with Read=MDRin=1 throughout; the instruction then completes normally.
- Opcode 5'h1F → illegal pulses for 1 cycle, no Rin asserted, retired unchanged, next state is F0.
- Opcode 5'h1B → halted=1 and busy=0 while held despite run=1, until clr.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the ALU operation sequencer.
//   - state_t     : sequencer states (fetch, decode, execute, halt)
//   - op_class_t  : instruction classes produced by op_decoder
//   - opcode constants and instruction field bit positions
//   - onehot16()  : 4-to-16 one-hot register-select decoder
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_F0,
    S_F1,
    S_F2,
    S_DEC,
    S_E3,
    S_E4,
    S_E5,
    S_E6,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_R3,    // Ra <- Rb op Rc
    CLS_HL,    // {HI,LO} <- Ra op Rb
    CLS_NOP,
    CLS_HALT,
    CLS_ILL
  } op_class_t;

  localparam logic [4:0] OP_R3_FIRST = 5'h03;
  localparam logic [4:0] OP_R3_LAST  = 5'h0B;
  localparam logic [4:0] OP_MUL      = 5'h0F;
  localparam logic [4:0] OP_DIV      = 5'h10;
  localparam logic [4:0] OP_NOP      = 5'h1A;
  localparam logic [4:0] OP_HALT     = 5'h1B;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    onehot16 = 16'h0001 << idx;
  endfunction

endpackage

// File: rtl/op_decoder.sv
// op_decoder: combinational opcode classifier.
//   opcode   in  5  instruction opcode
//   op_class out    instruction class (R3, HL, NOP, HALT, ILL)
//   alu_sel  out 5  ALU operation code (the opcode for R3/HL, else 0)
module op_decoder
  import ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_t  op_class,
  output logic [4:0] alu_sel
);

  // NOTE: every output gets a default before the decode so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    op_class = CLS_ILL;
    alu_sel  = '0;
    if (opcode >= OP_R3_FIRST && opcode <= OP_R3_LAST) begin
      op_class = CLS_R3;
      alu_sel  = opcode;
    end else if (opcode == OP_MUL || opcode == OP_DIV) begin
      op_class = CLS_HL;
      alu_sel  = opcode;
    end else if (opcode == OP_NOP) begin
      op_class = CLS_NOP;
    end else if (opcode == OP_HALT) begin
      op_class = CLS_HALT;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: hardwired Moore control sequencer for the CPU datapath.
// Runs the fetch cycle, decodes IR and sequences register-register ALU ops
// (R3) and multiply/divide ops writing HI/LO (HL).
//   clk, clr                 clock, async active-high reset
//   run, mem_rdy, ir         fetch permit, memory data valid, IR contents
//   PCout..Yin, ZLOout..HIin one-cycle datapath strobes
//   Rout, Rin                one-hot register drive / load enables
//   ALUSelection             ALU op code (E4 only)
//   busy, halted, illegal    status; illegal pulses the cycle after DEC
//   retired                  completed-instruction counter (wraps)
module alu_op_sequencer
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic             mem_rdy,
  input  logic [31:0]      ir,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             Zin,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             ZLOout,
  output logic             ZHIout,
  output logic             Loin,
  output logic             HIin,
  output logic [15:0]      Rout,
  output logic [15:0]      Rin,
  output logic [4:0]       ALUSelection,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t     state_q, state_d;
  logic [4:0] opcode_q;
  logic [3:0] ra_q, rb_q, rc_q;

  // In DEC the decoder looks at the live IR to pick the next state; in the
  // execute states it looks at the captured opcode, so IR may change freely
  // once DEC has passed.
  logic [4:0] dec_opcode;
  op_class_t  op_class;
  logic [4:0] alu_sel;

  assign dec_opcode = (state_q == S_DEC) ? ir[OPC_MSB:OPC_LSB] : opcode_q;

  op_decoder u_op_decoder (
    .opcode   (dec_opcode),
    .op_class (op_class),
    .alu_sel  (alu_sel)
  );

  // Low IR bits carry immediates/unused fields for these instructions.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[RC_LSB-1:0];

  logic exit_run;
  logic retire;

  assign exit_run = run;
  assign retire   = (state_q == S_E5 && op_class == CLS_R3) ||
                    (state_q == S_E6) ||
                    (state_q == S_DEC && op_class == CLS_NOP);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
      illegal  <= 1'b0;
      retired  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DEC) begin
        opcode_q <= ir[OPC_MSB:OPC_LSB];
        ra_q     <= ir[RA_MSB:RA_LSB];
        rb_q     <= ir[RB_MSB:RB_LSB];
        rc_q     <= ir[RC_MSB:RC_LSB];
      end
      illegal <= (state_q == S_DEC) && (op_class == CLS_ILL);
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (run) state_d = S_F0;
      S_F0:   state_d = S_F1;
      S_F1:   if (mem_rdy) state_d = S_F2;
      S_F2:   state_d = S_DEC;
      S_DEC: begin
        unique case (op_class)
          CLS_R3, CLS_HL: state_d = S_E3;
          CLS_HALT:       state_d = S_HALT;
          default:        state_d = exit_run ? S_F0 : S_IDLE;
        endcase
      end
      S_E3:   state_d = S_E4;
      S_E4:   state_d = S_E5;
      S_E5:   state_d = (op_class == CLS_HL) ? S_E6
                      : (exit_run ? S_F0 : S_IDLE);
      S_E6:   state_d = exit_run ? S_F0 : S_IDLE;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode from the registered state and captured fields.
  always_comb begin
    PCout        = 1'b0;
    MARin        = 1'b0;
    IncPC        = 1'b0;
    Zin          = 1'b0;
    PCin         = 1'b0;
    Read         = 1'b0;
    MDRin        = 1'b0;
    MDRout       = 1'b0;
    IRin         = 1'b0;
    Yin          = 1'b0;
    ZLOout       = 1'b0;
    ZHIout       = 1'b0;
    Loin         = 1'b0;
    HIin         = 1'b0;
    Rout         = '0;
    Rin          = '0;
    ALUSelection = '0;
    unique case (state_q)
      S_F0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      // PCin repeats on every stalled F1 cycle; harmless since Z is stable.
      S_F1: begin
        ZLOout = 1'b1;
        PCin   = 1'b1;
        Read   = 1'b1;
        MDRin  = 1'b1;
      end
      S_F2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_E3: begin
        Yin  = 1'b1;
        Rout = onehot16((op_class == CLS_HL) ? ra_q : rb_q);
      end
      S_E4: begin
        Zin          = 1'b1;
        ALUSelection = alu_sel;
        Rout         = onehot16((op_class == CLS_HL) ? rb_q : rc_q);
      end
      S_E5: begin
        ZLOout = 1'b1;
        if (op_class == CLS_HL) Loin = 1'b1;
        else                    Rin  = onehot16(ra_q);
      end
      S_E6: begin
        ZHIout = 1'b1;
        HIin   = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy   = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: self-checking bench for alu_op_sequencer. A reference
// model expands each instruction into its expected per-cycle output trace
// (with planned F1 stalls and run values), then the trace is replayed.
module tb_alu_op_sequencer;

  localparam int CNT_W = 4;  // small so the retired counter wraps quickly

  logic             clk = 1'b0;
  logic             clr, run, mem_rdy;
  logic [31:0]      ir;
  logic             PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin;
  logic             ZLOout, ZHIout, Loin, HIin;
  logic [15:0]      Rout, Rin;
  logic [4:0]       ALUSelection;
  logic             busy, halted, illegal;
  logic [CNT_W-1:0] retired;

  always #5 clk = ~clk;

  alu_op_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr), .run(run), .mem_rdy(mem_rdy), .ir(ir),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .PCin(PCin),
    .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .ZLOout(ZLOout), .ZHIout(ZHIout), .Loin(Loin), .HIin(HIin),
    .Rout(Rout), .Rin(Rin), .ALUSelection(ALUSelection),
    .busy(busy), .halted(halted), .illegal(illegal), .retired(retired)
  );

  typedef struct packed {
    logic pc_out, mar_in, inc_pc, z_in, pc_in, read, mdr_in, mdr_out, ir_in, y_in;
    logic zlo_out, zhi_out, lo_in, hi_in;
    logic [15:0] rout, rin;
    logic [4:0]  alu;
    logic busy, halted, illegal;
  } outs_t;

  typedef struct {
    string            tag;
    logic [31:0]      ir;
    logic             run;
    logic             rdy;
    outs_t            exp;
    logic [CNT_W-1:0] ret;
  } step_t;

  outs_t got;
  assign got = {PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
                ZLOout, ZHIout, Loin, HIin, Rout, Rin, ALUSelection,
                busy, halted, illegal};

  step_t            plan[$];
  int               tests, fails, cyc;
  logic [CNT_W-1:0] model_ret;
  bit               pending_ill;

  task automatic check(input string tag, input outs_t got_o, input outs_t exp_o,
                       input logic [CNT_W-1:0] got_r, input logic [CNT_W-1:0] exp_r);
    tests++;
    assert (got_o === exp_o) else begin
      fails++;
      $error("FAIL %s cyc=%0d outputs got=%h exp=%h", tag, cyc, got_o, exp_o);
    end
    tests++;
    assert (got_r === exp_r) else begin
      fails++;
      $error("FAIL %s cyc=%0d retired got=%0d exp=%0d", tag, cyc, got_r, exp_r);
    end
  endtask

  function automatic bit is_legal(input logic [4:0] op);
    return (op >= 5'h03 && op <= 5'h0B) || op == 5'h0F || op == 5'h10 ||
           op == 5'h1A || op == 5'h1B;
  endfunction

  task automatic push(input string tag, input outs_t o, input logic [31:0] irv,
                      input logic runv, input logic rdyv);
    step_t s;
    s.tag = tag;
    s.exp = o;
    if (pending_ill) begin
      s.exp.illegal = 1'b1;
      pending_ill   = 1'b0;
    end
    s.ir  = irv;
    s.run = runv;
    s.rdy = rdyv;
    s.ret = model_ret;
    plan.push_back(s);
  endtask

  task automatic plan_idle(input logic runv);
    outs_t o = '0;
    push("IDLE", o, $urandom, runv, 1'($urandom));
  endtask

  // Expected trace of one instruction. run is random wherever the sequencer
  // must ignore it; ir carries the instruction only in DEC.
  task automatic plan_instr(input logic [31:0] instr, input int stalls,
                            input logic run_after, input int halt_cycles);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    bit r3, hl, nop, hlt, ill;
    outs_t o;
    op  = instr[31:27];
    ra  = instr[26:23];
    rb  = instr[22:19];
    rc  = instr[18:15];
    r3  = (op >= 5'h03 && op <= 5'h0B);
    hl  = (op == 5'h0F || op == 5'h10);
    nop = (op == 5'h1A);
    hlt = (op == 5'h1B);
    ill = !is_legal(op);

    o = '0; o.busy = 1; o.pc_out = 1; o.mar_in = 1; o.inc_pc = 1; o.z_in = 1;
    push("F0", o, $urandom, 1'($urandom), 1'($urandom));
    for (int i = 0; i <= stalls; i++) begin
      o = '0; o.busy = 1; o.zlo_out = 1; o.pc_in = 1; o.read = 1; o.mdr_in = 1;
      push("F1", o, $urandom, 1'($urandom), 1'(i == stalls));
    end
    o = '0; o.busy = 1; o.mdr_out = 1; o.ir_in = 1;
    push("F2", o, $urandom, 1'($urandom), 1'($urandom));
    o = '0; o.busy = 1;
    push("DEC", o, instr, (nop || ill) ? run_after : 1'($urandom), 1'($urandom));
    if (nop) model_ret = model_ret + CNT_W'(1);
    if (ill) pending_ill = 1'b1;

    if (r3 || hl) begin
      o = '0; o.busy = 1; o.y_in = 1; o.rout = 16'h1 << (hl ? ra : rb);
      push("E3", o, $urandom, 1'($urandom), 1'($urandom));
      o = '0; o.busy = 1; o.z_in = 1; o.alu = op; o.rout = 16'h1 << (hl ? rb : rc);
      push("E4", o, $urandom, 1'($urandom), 1'($urandom));
      o = '0; o.busy = 1; o.zlo_out = 1;
      if (hl) o.lo_in = 1;
      else    o.rin = 16'h1 << ra;
      push("E5", o, $urandom, r3 ? run_after : 1'($urandom), 1'($urandom));
      if (hl) begin
        o = '0; o.busy = 1; o.zhi_out = 1; o.hi_in = 1;
        push("E6", o, $urandom, run_after, 1'($urandom));
      end
      model_ret = model_ret + CNT_W'(1);
    end

    if (hlt) begin
      for (int i = 0; i < halt_cycles; i++) begin
        o = '0; o.halted = 1;
        push("HALT", o, $urandom, 1'b1, 1'($urandom));
      end
    end else if (!run_after) begin
      plan_idle(1'b0);
      plan_idle(1'b1);
    end
  endtask

  task automatic run_queue(input int n);
    step_t s;
    for (int k = 0; k < n; k++) begin
      s = plan.pop_front();
      @(posedge clk);
      #1;
      ir      = s.ir;
      run     = s.run;
      mem_rdy = s.rdy;
      @(negedge clk);
      cyc++;
      check(s.tag, got, s.exp, retired, s.ret);
    end
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] instr;
    clr = 1'b1; run = 1'b0; mem_rdy = 1'b0; ir = '0;
    tests = 0; fails = 0; cyc = 0; model_ret = '0; pending_ill = 1'b0;

    repeat (2) @(negedge clk);
    check("reset", got, '0, retired, '0);
    clr = 1'b0;

    // Directed examples followed by a random instruction stream.
    plan_idle(1'b1);
    plan_instr(32'h28918000, 0, 1'b1, 0);                      // R3 op5 Ra1 Rb2 Rc3
    plan_instr({5'h10, 4'd6, 4'd7, 4'd0, 15'h0}, 0, 1'b1, 0);  // div Ra6 Rb7
    plan_instr(32'h28918000, 3, 1'b1, 0);                      // 3 stall cycles in F1
    plan_instr({5'h1F, 27'h0}, 0, 1'b1, 0);                    // illegal
    plan_instr({5'h03, 27'h0}, 0, 1'b0, 0);                    // Ra=Rb=Rc=R0, stop
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0, 1: op = 5'(5'h03 + $urandom_range(0, 8));
        2:    op = ($urandom_range(0, 1) != 0) ? 5'h0F : 5'h10;
        default: begin
          if ($urandom_range(0, 3) == 0) op = 5'h1A;
          else do op = 5'($urandom); while (is_legal(op));
        end
      endcase
      instr = {op, 27'($urandom)};
      plan_instr(instr, $urandom_range(0, 3), 1'($urandom_range(0, 3) != 0), 0);
    end
    run_queue(plan.size());

    // Abort an R3 in E4: everything must clear at once.
    plan_instr(32'h28918000, 0, 1'b1, 0);
    run_queue(plan.size() - 1);
    #1 clr = 1'b1;
    #1 check("clr_midE4", got, '0, retired, '0);
    @(negedge clk);
    check("clr_next", got, '0, retired, '0);
    plan.delete();
    model_ret = '0; pending_ill = 1'b0; run = 1'b0;
    clr = 1'b0;

    // NOP then HALT: HALT holds with run=1 until clr.
    plan_idle(1'b1);
    plan_instr({5'h1A, 27'h5A5A5A5}, 1, 1'b1, 0);
    plan_instr({5'h1B, 27'h0}, 0, 1'b1, 6);
    run_queue(plan.size());
    #1 clr = 1'b1;
    #1 check("halt_clr", got, '0, retired, '0);
    @(negedge clk);
    clr = 1'b0; run = 1'b0;
    @(negedge clk);
    check("idle_after", got, '0, retired, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
